// File: rtl/mc14500b_sequencer.sv
// Instruction-side sequencer for the MC14500B ICU: program counter, return stack,
// skip tracking, halt/resume and ICU reset sequencing.
module mc14500b_sequencer #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [ADDR_W+3:0] mem_rdata,
    output logic [3:0]        instruction,
    output logic [ADDR_W-1:0] io_addr,
    input  logic              jmp,
    input  logic              rtn,
    input  logic              flag_o,
    input  logic              flag_f,
    input  logic              rr_out,
    output logic              icu_rst,
    output logic              halted,
    output logic              sync_o,
    output logic              stack_err
);

    localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [3:0]  OP_SKZ  = 4'hE;
    localparam logic [3:0]  OP_NOPF = 4'hF;

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
    logic              hold_q, hold_d;
    logic              skip_q, skip_d;
    logic              sync_d, err_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic              push_en;
    logic [IDX_W-1:0]  push_idx, top_idx;
    logic              stack_full, stack_empty;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

    assign opcode      = mem_rdata[ADDR_W+3:ADDR_W];
    assign operand     = mem_rdata[ADDR_W-1:0];
    assign pc_inc      = pc_q + ADDR_W'(1);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign push_idx    = IDX_W'(sp_q);
    assign top_idx     = IDX_W'(sp_q - SP_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HOLD;
            pc_q      <= '0;
            hold_q    <= 1'b0;
            skip_q    <= 1'b0;
            sp_q      <= '0;
            sync_o    <= 1'b0;
            stack_err <= 1'b0;
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            hold_q    <= hold_d;
            skip_q    <= skip_d;
            sp_q      <= sp_d;
            sync_o    <= sync_d;
            stack_err <= err_d;
            if (push_en) begin
                stack_q[push_idx] <= pc_inc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hold_d  = hold_q;
        skip_d  = skip_q;
        sp_d    = sp_q;
        sync_d  = 1'b0;
        err_d   = stack_err;
        push_en = 1'b0;
        case (state_q)
            S_HOLD: begin
                hold_d = 1'b1;
                if (hold_q) begin
                    hold_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // A skipped word's ICU flags are stale/suppressed, so only advance.
                if (skip_q) begin
                    pc_d   = pc_inc;
                    skip_d = 1'b0;
                end else if (jmp) begin
                    pc_d = operand;
                    if (stack_full) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                    end
                end else if (rtn) begin
                    skip_d = 1'b1;
                    if (stack_empty) begin
                        pc_d  = '0;
                        err_d = 1'b1;
                    end else begin
                        pc_d = stack_q[top_idx];
                        sp_d = sp_q - SP_W'(1);
                    end
                end else if (opcode == OP_SKZ && !rr_out) begin
                    skip_d = 1'b1;
                    pc_d   = pc_inc;
                end else if (flag_f) begin
                    pc_d    = pc_inc;
                    state_d = S_HALT;
                end else if (flag_o) begin
                    pc_d   = pc_inc;
                    sync_d = 1'b1;
                end else begin
                    pc_d = pc_inc;
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    always_comb begin
        mem_addr    = pc_q;
        io_addr     = operand;
        icu_rst     = (state_q == S_HOLD);
        halted      = (state_q == S_HALT);
        instruction = (state_q == S_RUN) ? opcode : OP_NOPF;
    end

endmodule

// File: tb/tb_mc14500b_sequencer.sv
// Directed bench for mc14500b_sequencer with a behavioural ROM and a minimal ICU
// flag model decoded from the presented opcode.
module tb_mc14500b_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  mem_addr;
    logic [11:0] mem_rdata;
    logic [3:0]  instruction;
    logic [7:0]  io_addr;
    logic        jmp, rtn, flag_o, flag_f;
    logic        rr_out = 1'b0;
    logic        icu_rst, halted, sync_o, stack_err;

    logic [11:0] rom [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = rom[mem_addr];

    // ICU model: flags follow the opcode presented this cycle (even when skipped)
    always_comb begin
        jmp    = (instruction == 4'hC);
        rtn    = (instruction == 4'hD);
        flag_o = (instruction == 4'h0);
        flag_f = (instruction == 4'hF);
    end

    mc14500b_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instruction(instruction), .io_addr(io_addr),
        .jmp(jmp), .rtn(rtn), .flag_o(flag_o), .flag_f(flag_f), .rr_out(rr_out),
        .icu_rst(icu_rst), .halted(halted), .sync_o(sync_o), .stack_err(stack_err)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        start  = 1'b0;
        rr_out = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 12'h100;
    endtask

    // Leaves the bench at the negedge of the first RUN cycle (PC 0).
    task automatic release_run();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] ops [4];
        ops = '{4'h1, 4'h8, 4'h1, 4'h8};
        apply_reset();
        for (int i = 0; i < 4; i++) rom[i] = {ops[i], 8'(i)};
        #1;
        checks++;
        if ({icu_rst, halted, sync_o, stack_err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 1000", {icu_rst, halted, sync_o, stack_err});
        end
        checks++;
        if (mem_addr !== 8'h00 || instruction !== 4'hF) begin
            errors++;
            $display("FAIL reset_pc_instr got %h/%h exp 00/f", mem_addr, instruction);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (icu_rst !== 1'b1 || mem_addr !== 8'h00 || instruction !== 4'hF) begin
            errors++;
            $display("FAIL hold_cycle got rst=%b pc=%h ins=%h exp 1/00/f", icu_rst, mem_addr, instruction);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (icu_rst !== 1'b0 || mem_addr !== 8'(i) || instruction !== ops[i] || io_addr !== 8'(i)) begin
                errors++;
                $display("FAIL linear[%0d] got rst=%b pc=%h ins=%h io=%h exp 0/%h/%h/%h",
                         i, icu_rst, mem_addr, instruction, io_addr, 8'(i), ops[i], 8'(i));
            end
        end
    endtask

    task automatic test_call_return();
        logic [7:0] seq [14];
        seq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h20,
                8'h21, 8'h22, 8'h06, 8'h07, 8'h08, 8'h00, 8'h01};
        apply_reset();
        rom[8'h05] = 12'hC20;
        rom[8'h22] = 12'hD00;
        rom[8'h06] = 12'hF00;
        rom[8'h08] = 12'hD00;
        release_run();
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (mem_addr !== seq[i] || halted !== 1'b0 || stack_err !== (i >= 12)) begin
                errors++;
                $display("FAIL call_ret[%0d] got pc=%h halt=%b err=%b exp %h/0/%b",
                         i, mem_addr, halted, stack_err, seq[i], (i >= 12));
            end
        end
    endtask

    task automatic test_skz();
        logic [7:0] seq [4];
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 0) seq = '{8'h10, 8'h11, 8'h12, 8'h13};
            else           seq = '{8'h10, 8'h11, 8'h50, 8'h51};
            apply_reset();
            rr_out     = (pass == 1);
            rom[8'h10] = 12'hE00;
            rom[8'h11] = 12'hC50;
            release_run();
            repeat (16) @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (i > 0) @(negedge clk);
                checks++;
                if (mem_addr !== seq[i]) begin
                    errors++;
                    $display("FAIL skz_rr%0d[%0d] got pc=%h exp %h", pass, i, mem_addr, seq[i]);
                end
            end
        end
    endtask

    task automatic test_halt();
        apply_reset();
        rom[8'h30] = 12'hF00;
        release_run();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_addr !== 8'h03 || halted !== 1'b0) begin
            errors++;
            $display("FAIL start_in_run got pc=%h halt=%b exp 03/0", mem_addr, halted);
        end
        repeat (45) @(negedge clk);
        checks++;
        if (mem_addr !== 8'h30 || instruction !== 4'hF || halted !== 1'b0) begin
            errors++;
            $display("FAIL nopf_cycle got pc=%h ins=%h halt=%b exp 30/f/0", mem_addr, instruction, halted);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (mem_addr !== 8'h31 || instruction !== 4'hF || halted !== 1'b1) begin
                errors++;
                $display("FAIL halted[%0d] got pc=%h ins=%h halt=%b exp 31/f/1", i, mem_addr, instruction, halted);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (mem_addr !== 8'h31 || instruction !== 4'h1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL resume got pc=%h ins=%h halt=%b exp 31/1/0", mem_addr, instruction, halted);
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h32) begin
            errors++;
            $display("FAIL after_resume got pc=%h exp 32", mem_addr);
        end
    endtask

    task automatic test_sync();
        logic [2:0] exp_sync;
        exp_sync = 3'b010;
        apply_reset();
        rom[8'h40] = 12'h000;
        release_run();
        repeat (64) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (sync_o !== exp_sync[i] || mem_addr !== 8'(8'h40 + i)) begin
                errors++;
                $display("FAIL sync[%0d] got sync=%b pc=%h exp %b/%h",
                         i, sync_o, mem_addr, exp_sync[i], 8'(8'h40 + i));
            end
        end
    endtask

    task automatic test_stack_overflow();
        logic [7:0] seq [16];
        seq = '{8'h00, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'h81, 8'h82,
                8'h71, 8'h72, 8'h61, 8'h62, 8'h01, 8'h02, 8'h00, 8'h01};
        apply_reset();
        rom[8'h00] = 12'hC60;
        rom[8'h60] = 12'hC70;
        rom[8'h70] = 12'hC80;
        rom[8'h80] = 12'hC90;
        rom[8'h90] = 12'hCA0;
        rom[8'hA0] = 12'hD00;
        rom[8'h82] = 12'hD00;
        rom[8'h72] = 12'hD00;
        rom[8'h62] = 12'hD00;
        rom[8'h02] = 12'hD00;
        release_run();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (mem_addr !== seq[i] || stack_err !== (i >= 5)) begin
                errors++;
                $display("FAIL stack[%0d] got pc=%h err=%b exp %h/%b",
                         i, mem_addr, stack_err, seq[i], (i >= 5));
            end
        end
    endtask

    task automatic test_wrap_and_async_reset();
        logic [7:0] seq [5];
        seq = '{8'h00, 8'hFE, 8'hFF, 8'h00, 8'hFE};
        apply_reset();
        rom[8'h00] = 12'hCFE;
        release_run();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (mem_addr !== seq[i]) begin
                errors++;
                $display("FAIL wrap[%0d] got pc=%h exp %h", i, mem_addr, seq[i]);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (mem_addr !== 8'h00 || icu_rst !== 1'b1 || instruction !== 4'hF) begin
            errors++;
            $display("FAIL async_reset got pc=%h rst=%b ins=%h exp 00/1/f", mem_addr, icu_rst, instruction);
        end
        rom[8'h00] = 12'hD00;
        release_run();
        @(negedge clk);
        checks++;
        if (mem_addr !== 8'h00 || stack_err !== 1'b1) begin
            errors++;
            $display("FAIL stack_cleared got pc=%h err=%b exp 00/1", mem_addr, stack_err);
        end
    endtask

    initial begin
        test_reset();
        test_call_return();
        test_skz();
        test_halt();
        test_sync();
        test_stack_overflow();
        test_wrap_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc14500b_sequencer.md
# mc14500b_sequencer

Program sequencer on the instruction side of the MC14500B ICU. Owns the program counter, fetches words from an asynchronous-read program ROM, and drives the ICU's `instruction` bus plus an I/O address. It consumes the ICU's `jmp`, `rtn`, `flag_o`, `flag_f` and `rr_out` outputs to implement call/return, skip tracking, halt and sync strobes. It also sequences the ICU's synchronous active-high reset.

## Interface
- `ADDR_W`, 8: PC / ROM address width and operand width.
- `STACK_DEPTH`, 4: return-stack entries (≥1).
- `clk` in 1: clock, all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: leave HALT (level sampled on posedge).
- `mem_addr` out ADDR_W: ROM address, equals PC.
- `mem_rdata` in 4+ADDR_W: ROM word, combinational from `mem_addr`; [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand.
- `instruction` out 4: opcode to ICU.
- `io_addr` out ADDR_W: operand of presented word (I/O select / jump target).
- `jmp`, `rtn`, `flag_o`, `flag_f`, `rr_out` in 1 each: from ICU.
- `icu_rst` out 1: ICU reset, active high.
- `halted` out 1: high in HALT.
- `sync_o` out 1: one-cycle strobe per accepted NOPO.
- `stack_err` out 1: sticky stack over/underflow.

## Operation
- States: HOLD, RUN, HALT. Reset: state HOLD, PC 0, hold counter 0, skip_q 0, stack empty, `icu_rst` 1, `halted` 0, `sync_o` 0, `stack_err` 0.
- HOLD: `icu_rst`=1, `instruction`=0xF (NOPF), PC held. Lasts exactly 2 posedges after `rst_n` rises, then RUN.
- RUN: `instruction`=`mem_rdata` opcode, `io_addr`=operand, both combinational. Cycle is "accepted" iff skip_q=0.
- Accepted-cycle decisions at posedge (ICU flags reflect the word presented this cycle):
  - `jmp`: push PC+1 (mod 2^ADDR_W), PC ← operand.
  - `rtn`: pop into PC; skip_q ← 1.
  - opcode SKZ (0xE) and `rr_out`=0: skip_q ← 1; PC+1.
  - `flag_f`: PC ← PC+1, state HALT.
  - `flag_o`: `sync_o`=1 next cycle; PC+1.
  - otherwise PC+1.
- Skipped cycle (skip_q=1): all ICU flags ignored, no SKZ evaluation, PC+1, skip_q ← 0. ICU performs the matching skip internally; the first word at a return address is therefore skipped (programs place NOPF there).
- HALT: `instruction`=0xF, `halted`=1, PC held, ICU flags ignored. `start`=1 → RUN next cycle. `start` outside HALT ignored.
- PC wraps 2^ADDR_W−1 → 0 on increment.
- Stack push when full: push dropped, jump still taken, `stack_err` ← 1. Pop when empty: PC ← 0, `stack_err` ← 1. `stack_err` cleared only by reset.
- `rst_n` low at any time: immediate return to reset values, stack emptied, skip_q cleared.

## Timing
- Fetch-to-present latency 0: word at PC appears on `instruction` the same cycle.
- Branch penalty 0: cycle after accepted JMP presents target word; cycle after RTN presents return word (skipped).
- `sync_o` high exactly one cycle, the cycle after the accepted NOPO.
- HALT entry: the NOPF cycle is the last RUN cycle; `halted` rises next cycle. Exit: `start` sampled high → RUN on the following cycle with PC unchanged.
- `icu_rst` falls on the same posedge as HOLD→RUN; first RUN cycle presents word 0.

## Test plan
- Reset release, ROM linear LD/STO at 0..3 → `icu_rst` high 2 cycles after `rst_n`↑, then `mem_addr` 0,1,2,3 on consecutive cycles.
- JMP 0x20 at 0x05, RTN at 0x22 → `mem_addr` 05,20,21,22,06(skipped, flags ignored),07; stack empty afterwards.
- SKZ at 0x10 with `rr_out`=0 and JMP at 0x11 → 0x11 presented, `jmp` ignored, next 0x12; with `rr_out`=1 → jump taken.
- NOPF at 0x30 → `halted`=1 from next cycle, `mem_addr` held 0x31, `instruction`=0xF; `start` pulse → resumes at 0x31. NOPO at 0x40 → `sync_o` one cycle.
- STACK_DEPTH=4, five nested JMPs → `stack_err`=1, fifth jump taken; RTN on empty stack → PC 0, `stack_err` stays 1.
- PC 0xFF plain instruction → next `mem_addr` 0x00; `rst_n` low mid-subroutine → HOLD, stack empty, PC 0.
